prepare_ok_eng: RTL and testbench



---
 rtl/prepare_ok_eng.sv | 263 ++++++++++++++++++++++++++
 tb/tb_prepare_ok_eng.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prepare_ok_eng.sv
// PrepareOK engine: collects backup acks per op in a ring of vote masks,
// advances the commit number in order on quorum and publishes each change.
package prepare_ok_eng_pkg;
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;
endpackage

module prepare_ok_eng
    import prepare_ok_eng_pkg::*;
#(
    parameter int NOC_DATA_W   = 512,
    parameter int NUM_REPLICAS = 3,
    parameter int WINDOW_DEPTH = 64,
    parameter int REPLICA_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  manage_pok_msg_val,
    input  udp_info               manage_pok_pkt_info,
    output logic                  pok_manage_msg_rdy,
    input  logic                  manage_pok_req_val,
    input  logic [NOC_DATA_W-1:0] manage_pok_req,
    input  logic                  manage_pok_req_last,
    output logic                  pok_manage_req_rdy,
    input  logic [63:0]           cur_view,
    input  logic [63:0]           last_prep_op,
    input  logic [REPLICA_W-1:0]  my_idx,
    input  logic                  view_change,
    input  logic [63:0]           commit_load,
    output logic                  pok_commit_val,
    output logic [63:0]           pok_commit_num,
    input  logic                  commit_pok_rdy,
    output logic [63:0]           commit_num,
    output logic [31:0]           drop_cnt
);

    localparam int WIN_W  = $clog2(WINDOW_DEPTH);
    localparam int QUORUM = (NUM_REPLICAS - 1) / 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SCAN   = 3'd3,
        ST_NOTIFY = 3'd4
    } state_t;

    function automatic int popcount(input logic [NUM_REPLICAS-1:0] m);
        int cnt;
        cnt = 0;
        for (int j = 0; j < NUM_REPLICAS; j++) begin
            cnt = cnt + int'(m[j]);
        end
        return cnt;
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;
    logic [63:0]             r_view;
    logic [63:0]             r_op;
    logic [REPLICA_W-1:0]    r_ridx;
    logic                    r_aborted;
    logic                    r_advanced;
    logic [63:0]             r_commit_num;
    logic                    r_pok_val;
    logic [63:0]             r_pok_num;
    logic [31:0]             r_drop_cnt;
    logic [NUM_REPLICAS-1:0] r_mask [WINDOW_DEPTH];

    logic                    w_capture;
    logic                    w_set_vote;
    logic                    w_drop;
    logic                    w_advance;
    logic                    w_notify_start;
    logic                    w_notify_done;
    logic                    w_abort;
    logic                    w_msg_valid;
    logic                    w_quorate;
    logic [63:0]             w_dist;
    logic [63:0]             w_head;
    logic [WIN_W-1:0]        w_head_slot;
    logic [WIN_W-1:0]        w_op_slot;
    logic                    w_unused;

    // Only the header fields of the first flit and the handshakes carry meaning.
    assign w_unused = ^{manage_pok_pkt_info, manage_pok_req};

    assign w_dist      = r_op - r_commit_num;
    assign w_head      = r_commit_num + 64'd1;
    assign w_head_slot = w_head[WIN_W-1:0];
    assign w_op_slot   = r_op[WIN_W-1:0];

    assign w_msg_valid = (r_view == cur_view) && (r_commit_num < r_op) &&
                         (r_op <= last_prep_op) && (w_dist <= 64'(WINDOW_DEPTH)) &&
                         (r_ridx < REPLICA_W'(NUM_REPLICAS)) && (r_ridx != my_idx);

    assign w_quorate = (popcount(r_mask[w_head_slot]) >= QUORUM) && (w_head <= last_prep_op);

    assign pok_commit_val = r_pok_val;
    assign pok_commit_num = r_pok_num;
    assign commit_num     = r_commit_num;
    assign drop_cnt       = r_drop_cnt;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, handshakes and datapath strobes; view_change overrides all.
    always_comb begin
        w_next_state       = r_state;
        pok_manage_msg_rdy = 1'b0;
        pok_manage_req_rdy = 1'b0;
        w_capture          = 1'b0;
        w_set_vote         = 1'b0;
        w_drop             = 1'b0;
        w_advance          = 1'b0;
        w_notify_start     = 1'b0;
        w_notify_done      = 1'b0;
        w_abort            = 1'b0;
        if (view_change) begin
            // Flits of an interrupted message are still consumed up to last.
            pok_manage_req_rdy = (r_state == ST_DRAIN);
            if ((r_state == ST_DRAIN) && !(manage_pok_req_val && manage_pok_req_last)) begin
                w_next_state = ST_DRAIN;
                w_abort      = 1'b1;
            end else begin
                w_next_state = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (manage_pok_msg_val && manage_pok_req_val) begin
                        pok_manage_msg_rdy = 1'b1;
                        pok_manage_req_rdy = 1'b1;
                        w_capture          = 1'b1;
                        w_next_state       = manage_pok_req_last ? ST_CHECK : ST_DRAIN;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    pok_manage_req_rdy = 1'b1;
                    if (manage_pok_req_val && manage_pok_req_last) begin
                        w_next_state = r_aborted ? ST_IDLE : ST_CHECK;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end
                ST_CHECK: begin
                    if (w_msg_valid) begin
                        w_set_vote   = 1'b1;
                        w_next_state = ST_SCAN;
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_quorate) begin
                        w_advance    = 1'b1;
                        w_next_state = ST_SCAN;
                    end else if (r_advanced) begin
                        w_notify_start = 1'b1;
                        w_next_state   = ST_NOTIFY;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_NOTIFY: begin
                    if (commit_pok_rdy) begin
                        w_notify_done = 1'b1;
                        w_next_state  = ST_IDLE;
                    end else begin
                        w_next_state = ST_NOTIFY;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Captured header, commit progress, notification register and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_view       <= 64'd0;
            r_op         <= 64'd0;
            r_ridx       <= '0;
            r_aborted    <= 1'b0;
            r_advanced   <= 1'b0;
            r_commit_num <= 64'd0;
            r_pok_val    <= 1'b0;
            r_pok_num    <= 64'd0;
            r_drop_cnt   <= 32'd0;
        end else begin
            if (w_capture) begin
                r_view    <= manage_pok_req[NOC_DATA_W-1 -: 64];
                r_op      <= manage_pok_req[NOC_DATA_W-65 -: 64];
                r_ridx    <= manage_pok_req[NOC_DATA_W-129 -: REPLICA_W];
                r_aborted <= 1'b0;
            end
            if (w_abort) begin
                r_aborted <= 1'b1;
            end
            if (view_change) begin
                r_commit_num <= commit_load;
                r_pok_val    <= 1'b0;
                r_advanced   <= 1'b0;
            end else begin
                if (w_set_vote) begin
                    r_advanced <= 1'b0;
                end
                if (w_advance) begin
                    r_commit_num <= w_head;
                    r_advanced   <= 1'b1;
                end
                if (w_notify_start) begin
                    r_pok_val <= 1'b1;
                    r_pok_num <= r_commit_num;
                end
                if (w_notify_done) begin
                    r_pok_val <= 1'b0;
                end
            end
            if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    // Vote ring: set on a valid ack, cleared on commit of that slot or view change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < WINDOW_DEPTH; s++) begin
                r_mask[s] <= '0;
            end
        end else begin
            for (int s = 0; s < WINDOW_DEPTH; s++) begin
                for (int j = 0; j < NUM_REPLICAS; j++) begin
                    if (view_change) begin
                        r_mask[s][j] <= 1'b0;
                    end else if (w_set_vote && (w_op_slot == WIN_W'(s)) && (r_ridx == REPLICA_W'(j))) begin
                        r_mask[s][j] <= 1'b1;
                    end else if (w_advance && (w_head_slot == WIN_W'(s))) begin
                        r_mask[s][j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prepare_ok_eng.sv
// Randomized bench for prepare_ok_eng against an op-keyed ack/quorum model.
module tb_prepare_ok_eng;
    import prepare_ok_eng_pkg::*;

    localparam int W  = 512;
    localparam int NR = 3;
    localparam int F  = (NR - 1) / 2;

    logic          clk;
    logic          rst_n;
    logic          msg_val;
    udp_info       pkt_info;
    logic          msg_rdy;
    logic          req_val;
    logic [W-1:0]  req;
    logic          req_last;
    logic          req_rdy;
    logic [63:0]   cur_view;
    logic [63:0]   last_prep_op;
    logic [7:0]    my_idx;
    logic          view_change;
    logic [63:0]   commit_load;
    logic          pok_val;
    logic [63:0]   pok_num;
    logic          pok_rdy;
    logic [63:0]   commit_num;
    logic [31:0]   drop_cnt;

    int n_checks;
    int n_errors;

    longint unsigned m_commit;
    int unsigned     m_drop;
    bit [NR-1:0]     m_acks [longint unsigned];

    prepare_ok_eng #(.NOC_DATA_W(W), .NUM_REPLICAS(NR), .WINDOW_DEPTH(64), .REPLICA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .manage_pok_msg_val(msg_val), .manage_pok_pkt_info(pkt_info), .pok_manage_msg_rdy(msg_rdy),
        .manage_pok_req_val(req_val), .manage_pok_req(req), .manage_pok_req_last(req_last),
        .pok_manage_req_rdy(req_rdy),
        .cur_view(cur_view), .last_prep_op(last_prep_op), .my_idx(my_idx),
        .view_change(view_change), .commit_load(commit_load),
        .pok_commit_val(pok_val), .pok_commit_num(pok_num), .commit_pok_rdy(pok_rdy),
        .commit_num(commit_num), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_flit(input logic [63:0] v, input logic [63:0] op, input logic [7:0] r);
        logic [W-1:0] f;
        f = {16{$urandom()}};
        f[W-1 -: 64]   = v;
        f[W-65 -: 64]  = op;
        f[W-129 -: 8]  = r;
        return f;
    endfunction

    // Commit every head op that has enough backup acks; returns number of advances.
    function automatic int model_advance();
        int adv;
        longint unsigned h;
        int cnt;
        adv = 0;
        while (adv < 1000) begin
            h   = m_commit + 1;
            cnt = m_acks.exists(h) ? $countones(m_acks[h]) : 0;
            if (cnt >= F && h <= last_prep_op) begin
                m_acks.delete(h);
                m_commit = h;
                adv++;
            end else begin
                break;
            end
        end
        return adv;
    endfunction

    function automatic bit model_ok(input logic [63:0] v, input logic [63:0] op, input logic [7:0] r);
        return (v == cur_view) && (op > m_commit) && (op <= last_prep_op) &&
               ((op - m_commit) <= 64) && (r < NR) && (r != my_idx);
    endfunction

    // mode 0: normal ack after hold; 1: view_change during NOTIFY; 2: view_change mid-drain.
    task automatic send_msg(input logic [63:0] v, input logic [63:0] op, input logic [7:0] r,
                            input int nfl, input int hold, input int mode, input logic [63:0] load);
        int tries;
        int first;
        int n;
        int adv;
        int bound;
        logic [63:0] held;
        bit [NR-1:0] one;
        @(negedge clk);
        msg_val = 1'b1; req_val = 1'b1; req = mk_flit(v, op, r); req_last = (nfl == 1);
        #1;
        tries = 0;
        while (!(msg_rdy && req_rdy) && tries < 20) begin
            @(negedge clk); #1; tries++;
        end
        check_value("accept", {62'd0, msg_rdy, req_rdy}, 64'd3);
        @(posedge clk);
        for (int i = 1; i < nfl; i++) begin
            @(negedge clk);
            view_change = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                req_val = 1'b0; req_last = 1'b0;
                @(negedge clk);
            end
            req_val = 1'b1; req = {16{$urandom()}}; req_last = (i == nfl - 1);
            if (mode == 2 && i == 1) begin
                view_change = 1'b1; commit_load = load;
            end
            #1;
            check_value("no_meta_in_drain", {63'd0, msg_rdy}, 64'd0);
            check_value("drain_rdy", {63'd0, req_rdy}, 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        view_change = 1'b0; msg_val = 1'b0; req_val = 1'b0; req_last = 1'b0;
        adv = 0;
        if (mode == 2) begin
            m_acks.delete();
            m_commit = load;
        end else if (model_ok(v, op, r)) begin
            one = 1;
            m_acks[op] = m_acks.exists(op) ? (m_acks[op] | (one << r)) : (one << r);
            adv = model_advance();
        end else begin
            m_drop++;
        end
        bound = (adv > 0) ? (adv + 8) : 8;
        first = -1;
        n = 0;
        while (n < bound) begin
            if (pok_val) begin
                first = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (adv > 0) begin
            check_value("latency", 64'(first), 64'(2 + adv));
            if (first >= 0) begin
                check_value("pok_num", pok_num, m_commit);
                held = pok_num;
                if (mode == 1) begin
                    view_change = 1'b1; commit_load = load;
                    @(negedge clk);
                    view_change = 1'b0;
                    check_value("vc_cancels_notify", {63'd0, pok_val}, 64'd0);
                    m_acks.delete();
                    m_commit = load;
                end else begin
                    repeat (hold) begin
                        @(negedge clk);
                        check_value("hold_val", {63'd0, pok_val}, 64'd1);
                        check_value("hold_num_stable", pok_num, held);
                    end
                    pok_rdy = 1'b1;
                    @(negedge clk);
                    pok_rdy = 1'b0;
                    check_value("val_after_ack", {63'd0, pok_val}, 64'd0);
                end
            end
        end else begin
            check_value("no_update", {63'd0, first >= 0}, 64'd0);
        end
        check_value("commit_num", commit_num, m_commit);
        check_value("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic pulse_vc(input logic [63:0] load);
        @(negedge clk);
        view_change = 1'b1; commit_load = load;
        @(negedge clk);
        view_change = 1'b0;
        m_acks.delete();
        m_commit = load;
        check_value("vc_load", commit_num, m_commit);
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] op;
        logic [7:0]  r;
        int nfl;
        int mode;
        int md;
        n_checks = 0; n_errors = 0;
        m_commit = 0; m_drop = 0;
        rst_n = 1'b0; msg_val = 1'b0; req_val = 1'b0; req = '0; req_last = 1'b0;
        pkt_info = '0; cur_view = 64'd5; last_prep_op = 64'd10; my_idx = 8'd0;
        view_change = 1'b0; commit_load = 64'd0; pok_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_msg_rdy", {63'd0, msg_rdy}, 64'd0);
        check_value("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
        check_value("rst_pok_val", {63'd0, pok_val}, 64'd0);
        check_value("rst_pok_num", pok_num, 64'd0);
        check_value("rst_commit", commit_num, 64'd0);
        check_value("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;

        send_msg(64'd5, 64'd1, 8'd1, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd3, 8'd2, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd2, 8'd2, 1, 1, 0, 64'd0);
        send_msg(64'd4, 64'd4, 8'd1, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd11, 8'd1, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd4, 8'd0, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd4, 8'd3, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd4, 8'd1, 3, 5, 0, 64'd0);
        send_msg(64'd5, 64'd5, 8'd1, 1, 0, 1, 64'd7);
        send_msg(64'd5, 64'd8, 8'd2, 1, 0, 0, 64'd0);

        last_prep_op = 64'd100;
        pulse_vc(64'd0);
        send_msg(64'd5, 64'd65, 8'd1, 1, 0, 0, 64'd0);
        send_msg(64'd5, 64'd64, 8'd1, 1, 0, 0, 64'd0);
        for (int k = 1; k <= 63; k++) begin
            send_msg(64'd5, 64'(k), 8'(1 + (k % 2)), 1, 0, 0, 64'd0);
        end
        send_msg(64'd5, 64'd60, 8'd1, 2, 0, 2, 64'd20);

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) == 0) my_idx = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) last_prep_op = m_commit + $urandom_range(0, 70);
            v  = ($urandom_range(0, 7) == 0) ? cur_view - 64'd1 : cur_view;
            op = ($urandom_range(0, 4) == 0) ? m_commit + $urandom_range(0, 70) : m_commit + $urandom_range(1, 4);
            r  = 8'($urandom_range(0, 3));
            nfl = $urandom_range(1, 4);
            md  = $urandom_range(0, 19);
            mode = (md == 0) ? 2 : ((md < 3) ? 1 : 0);
            if (mode == 2 && nfl < 3) nfl = 3;
            send_msg(v, op, r, nfl, $urandom_range(0, 3), mode, 64'($urandom_range(0, 40)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
